instruction_loader: RTL
=======================

# instruction_loader

Boot-time loader that sits directly upstream of the single-cycle MIPS processor's instruction memory. It accepts a framed byte stream: a 16-bit big-endian word count, then that many 32-bit big-endian instruction words. It packs the bytes into words and writes them to consecutive instruction-memory addresses starting at 0. When loading completes it raises `cpu_run`, which releases the processor.

## Interface
- `ADDR_WIDTH`, 8: instruction-memory word-address width; depth = 2**ADDR_WIDTH words.
- `WORD_WIDTH`, 32: instruction word width; fixed at 32 for the MIPS core.

- `clock`  in  1  system clock, rising-edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  single-cycle pulse; begins a load from IDLE.
- `in_valid`  in  1  byte-stream valid.
- `in_byte`  in  8  byte-stream data.
- `in_ready`  out  1  loader can accept a byte this cycle.
- `mem_we`  out  1  instruction-memory write enable, one-cycle pulse.
- `mem_addr`  out  ADDR_WIDTH  instruction-memory word address.
- `mem_wdata`  out  WORD_WIDTH  instruction word to write.
- `cpu_run`  out  1  processor release; high only in DONE.
- `done`  out  1  load completed successfully.
- `error`  out  1  header count exceeded memory depth.

## Operation
- States: IDLE, LEN_HI, LEN_LO, DATA, DONE, ERR.
- Byte accept: a byte is taken when `in_valid && in_ready`.
- `in_ready` is high only in LEN_HI, LEN_LO and DATA.
- IDLE: on `start`, go to LEN_HI. `start` is ignored in every other state.
- LEN_HI: accepted byte becomes `count[15:8]`; go to LEN_LO.
- LEN_LO: accepted byte becomes `count[7:0]`. Evaluate the full count:
  - count == 0: go to DONE.
  - count > 2**ADDR_WIDTH: go to ERR.
  - otherwise: go to DATA with word index 0 and byte index 0.
- DATA byte packing: bytes shift in MSB-first; byte 0 lands in `[31:24]`.
- DATA 4th byte accepted:
  - Register `mem_wdata` = assembled word and `mem_addr` = word index.
  - Pulse `mem_we` for one cycle.
  - Increment the word index and reset the byte index.
- DATA last word written: go to DONE.
- DONE: `done` = 1 and `cpu_run` = 1. Hold until reset. `in_ready` = 0.
- ERR: `error` = 1 and `cpu_run` = 0. Hold until reset. No memory writes occur.
- Address width rules:
  - Word index is ADDR_WIDTH+1 bits wide, so count == 2**ADDR_WIDTH is legal.
  - `mem_addr` carries the low ADDR_WIDTH bits; it never wraps within a legal load.
- Reset mid-operation:
  - All state and counters clear immediately; the partial word is discarded.
  - Memory contents are not cleared.
- Bytes presented while `in_ready` = 0 are not consumed. The source must hold them.

## Timing
- Reset values: `in_ready`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `cpu_run`=0, `done`=0, `error`=0. State is IDLE.
- `start` sampled at cycle N: `in_ready`=1 from cycle N+1.
- Write latency: `mem_we` is high in the cycle after the accepting edge of a word's 4th byte, with `mem_addr` and `mem_wdata` valid in that same cycle.
- Throughput: full rate, one byte per cycle. `in_ready` stays high across word boundaries while words remain.
- `in_ready` drops in the cycle after the final byte is accepted.
- `done`/`cpu_run` rise in the same cycle as the final `mem_we` pulse.
- count==0: `done` rises the cycle after the LEN_LO byte is accepted.
- count too large: `error` rises the cycle after the LEN_LO byte is accepted.
- All outputs are registered.

## Structure
- Package `loader_pkg`:
  - state enum `loader_state_t`;
  - `HDR_BYTES` = 2;
  - `BYTES_PER_WORD` = 4.
- Sub-module `byte_word_packer`:
  - shift register plus 2-bit byte counter;
  - inputs: `clock`, `reset`, `shift_en`, `clear`, `in_byte`;
  - outputs: `word`, `word_full` (high on the 4th shift).
- Top level: FSM, length register, word-index counter and registered memory-write outputs.

## Test plan
- Reset mid-DATA: after 2 of 4 bytes, assert `reset`, then reload count=1 with word 0xDEADBEEF → single write `mem_addr`=0, `mem_wdata`=0xDEADBEEF; no write of the partial word.
- Nominal load: `start`; bytes 00 03 then 0x20080005, 0x20090007, 0x01095020 streamed back-to-back → three `mem_we` pulses at addresses 0,1,2 with those values; `done`=`cpu_run`=1; `in_ready`=0 afterwards.
- Backpressure/gaps: same frame with `in_valid` toggled randomly → identical writes; no byte lost or duplicated.
- count=0: bytes 00 00 → `done`=1 with no `mem_we`.
- Overflow: ADDR_WIDTH=8, header 01 01 (257) → `error`=1, `cpu_run`=0, no `mem_we`, `in_ready`=0.
- Full depth and ignored start: header 01 00 (256) → last write at `mem_addr`=255; a `start` pulse in DONE has no effect.

Source files
------------

// File: rtl/loader_pkg.sv
// loader_pkg: shared types and constants for the instruction loader.
//   loader_state_t : loader FSM states
//   HDR_BYTES      : bytes in the big-endian word-count header
//   BYTES_PER_WORD : bytes packed into one instruction word
package loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_HI = 3'd1,
    ST_LEN_LO = 3'd2,
    ST_DATA   = 3'd3,
    ST_DONE   = 3'd4,
    ST_ERR    = 3'd5
  } loader_state_t;

  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/byte_word_packer.sv
// byte_word_packer: packs a byte stream MSB-first into 32-bit words.
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   shift_en     : shift in_byte this cycle
//   clear        : discard any partial word and restart at byte 0
//   in_byte      : incoming byte
//   word         : assembled word including the byte being shifted now
//   word_full    : high on the cycle the 4th byte is shifted in
module byte_word_packer
  import loader_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        shift_en,
  input  logic        clear,
  input  logic [7:0]  in_byte,
  output logic [31:0] word,
  output logic        word_full
);

  // Only the first three bytes need storage; the fourth is taken live so
  // the complete word is available on the same edge that accepts it.
  logic [23:0] shift_reg;
  logic [31:0] shift_next;
  logic [1:0]  cnt_reg;

  genvar gi;
  generate
    for (gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane
      if (gi == 0) begin : g_first
        assign shift_next[7:0] = in_byte;
      end else begin : g_rest
        assign shift_next[8*gi +: 8] = shift_reg[8*(gi-1) +: 8];
      end
    end
  endgenerate

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shift_reg <= '0;
      cnt_reg   <= '0;
    end else if (clear) begin
      shift_reg <= '0;
      cnt_reg   <= '0;
    end else if (shift_en) begin
      shift_reg <= shift_next[23:0];
      cnt_reg   <= cnt_reg + 2'd1;
    end
  end

  assign word      = shift_next;
  assign word_full = shift_en && (cnt_reg == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/instruction_loader.sv
// instruction_loader: boot-time loader feeding the MIPS instruction memory.
// Accepts a 16-bit big-endian word count followed by that many 32-bit
// big-endian words, writes them to addresses 0.. and then releases the CPU.
//   clock, reset         : rising-edge clock, asynchronous active-high reset
//   start                : one-cycle pulse, begins a load from IDLE
//   in_valid/in_byte     : byte stream; accepted when in_valid && in_ready
//   in_ready             : loader can take a byte this cycle
//   mem_we/addr/wdata    : registered instruction-memory write port
//   cpu_run, done        : high once the load has completed
//   error                : header count exceeded memory depth
module instruction_loader
  import loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int WORD_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [7:0]            in_byte,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WORD_WIDTH-1:0] mem_wdata,
  output logic                  cpu_run,
  output logic                  done,
  output logic                  error
);

  // One extra bit so a load of exactly 2**ADDR_WIDTH words is representable.
  localparam int IDX_W = ADDR_WIDTH + 1;

  loader_state_t    state_reg;
  logic [7:0]       len_hi_reg;
  logic [IDX_W-1:0] total_reg;
  logic [IDX_W-1:0] word_idx_reg;
  logic [IDX_W-1:0] word_idx_next;
  logic [15:0]      count_next;

  logic        accept;
  logic        pk_shift;
  logic        pk_clear;
  logic [31:0] pk_word;
  logic        pk_full;

  assign accept        = in_valid && in_ready;
  assign count_next    = {len_hi_reg, in_byte};
  assign word_idx_next = word_idx_reg + 1'b1;
  assign pk_shift      = accept && (state_reg == ST_DATA);
  // Start every frame's payload from byte 0 regardless of history.
  assign pk_clear      = accept && (state_reg == ST_LEN_LO);

  byte_word_packer u_packer (
    .clock     (clock),
    .reset     (reset),
    .shift_en  (pk_shift),
    .clear     (pk_clear),
    .in_byte   (in_byte),
    .word      (pk_word),
    .word_full (pk_full)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      len_hi_reg   <= '0;
      total_reg    <= '0;
      word_idx_reg <= '0;
      in_ready     <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      cpu_run      <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      unique case (state_reg)
        ST_IDLE: begin
          if (start) begin
            state_reg <= ST_LEN_HI;
            in_ready  <= 1'b1;
          end
        end
        ST_LEN_HI: begin
          if (accept) begin
            len_hi_reg <= in_byte;
            state_reg  <= ST_LEN_LO;
          end
        end
        ST_LEN_LO: begin
          if (accept) begin
            if (count_next == 16'd0) begin
              state_reg <= ST_DONE;
              in_ready  <= 1'b0;
              done      <= 1'b1;
              cpu_run   <= 1'b1;
            end else if (32'(count_next) > (32'd1 << ADDR_WIDTH)) begin
              state_reg <= ST_ERR;
              in_ready  <= 1'b0;
              error     <= 1'b1;
            end else begin
              state_reg    <= ST_DATA;
              total_reg    <= IDX_W'(count_next);
              word_idx_reg <= '0;
            end
          end
        end
        ST_DATA: begin
          if (pk_full) begin
            mem_we       <= 1'b1;
            mem_addr     <= word_idx_reg[ADDR_WIDTH-1:0];
            mem_wdata    <= WORD_WIDTH'(pk_word);
            word_idx_reg <= word_idx_next;
            if (word_idx_next == total_reg) begin
              state_reg <= ST_DONE;
              in_ready  <= 1'b0;
              done      <= 1'b1;
              cpu_run   <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          state_reg <= ST_DONE;
        end
        ST_ERR: begin
          state_reg <= ST_ERR;
        end
        default: begin
          state_reg <= ST_IDLE;
          in_ready  <= 1'b0;
        end
      endcase
    end
  end

endmodule
